// File: rtl/uart_tx_fifo.sv
// Purpose: byte FIFO feeding a UART transmitter's start/tx_data_in handshake, one launch per stored byte in order.
// Latency: byte written at edge N into an idle, empty block -> start high from edge N+1 to N+2, tx_data_in valid from N+1.
// Backpressure: wr_ready = !full (registered count); optional UART_TX_FIFO_STATS_EN adds launch/drop counters.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    output logic [DATA_WIDTH-1:0]        tx_data_in,
    output logic                         start,
    input  logic                         tx_active,
    input  logic                         done_tx,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output logic                         full
`ifdef UART_TX_FIFO_STATS_EN
    ,
    output logic [15:0]                  tx_count,
    output logic [15:0]                  drop_count,
    input  logic                         stats_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP,
        S_DRAIN
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    state_t                state_q, state_d;
    logic [7:0]            gap_q, gap_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  start_q, start_d;
    logic                  pop;
    logic                  wr_en;
    logic                  empty_w, full_w;

    assign empty_w    = (count_q == '0);
    assign full_w     = (count_q == CW'(DEPTH));
    assign wr_en      = wr_valid && !full_w;

    assign count      = count_q;
    assign empty      = empty_w;
    assign full       = full_w;
    assign wr_ready   = !full_w;
    assign tx_data_in = tx_data_q;
    assign start      = start_q;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count is an independent up/down counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Launch FSM state, gap counter and registered UART-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            tx_data_q <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            start_q   <= start_d;
        end
    end

    // Next-state logic: launch head byte, wait for completion, idle gap, then wait for UART to settle.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        tx_data_d = tx_data_q;
        start_d   = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_w && !tx_active) begin
                    state_d   = S_LAUNCH;
                    tx_data_d = mem[rd_ptr_q];
                    start_d   = 1'b1;
                    pop       = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_tx) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = 8'(GAP_CYCLES);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = S_DRAIN;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_DRAIN: begin
                // A level-held done_tx must drop before the next launch is considered.
                if (!done_tx && !tx_active) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] tx_count_q, drop_count_q;

    assign tx_count   = tx_count_q;
    assign drop_count = drop_count_q;

    // Saturating launch and refused-write counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_count_q   <= '0;
            drop_count_q <= '0;
        end else if (stats_clr) begin
            tx_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            if (pop && (tx_count_q != 16'hFFFF)) begin
                tx_count_q <= tx_count_q + 16'd1;
            end
            if (wr_valid && full_w && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose: self-checking bench for uart_tx_fifo with a behavioural UART responder and a queue scoreboard.
// Latency: checks exact single-byte launch timing plus per-launch gap after done_tx.
// Backpressure: holds tx_active to fill the FIFO, then hammers wr_valid while full.
module tb_uart_tx_fifo;

    localparam int DW   = 8;
    localparam int DEP  = 16;
    localparam int GAP  = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] tx_data_in;
    logic          start;
    logic          tx_active;
    logic          done_tx;
    logic [4:0]    count;
    logic          empty;
    logic          full;

    uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx_data_in (tx_data_in),
        .start      (start),
        .tx_active  (tx_active),
        .done_tx    (done_tx),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // UART responder state
    logic          uart_hold;
    logic          uart_busy;
    logic [DW-1:0] rx_byte;
    int            ust;
    int            ucnt;

    // Scoreboard state
    logic [DW-1:0] model_q[$];
    logic          pend;
    logic [DW-1:0] pend_dat;
    logic          prev_start;
    logic          prev_done;
    logic          done_seen;
    int            done_cyc;
    int            launches = 0;

    assign tx_active = uart_hold | uart_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural UART: accept a launch, stay busy a random time, then hold done_tx for 1..3 cycles.
    initial begin
        uart_busy = 1'b0;
        done_tx   = 1'b0;
        rx_byte   = '0;
        ust       = 0;
        ucnt      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                ust       = 0;
                uart_busy = 1'b0;
                done_tx   = 1'b0;
            end else begin
                case (ust)
                    0: if (start) begin
                        rx_byte   = tx_data_in;
                        uart_busy = 1'b1;
                        ucnt      = $urandom_range(1, 6);
                        ust       = 1;
                    end
                    1: begin
                        chk("tx_data_hold", tx_data_in, rx_byte);
                        ucnt--;
                        if (ucnt == 0) begin
                            uart_busy = 1'b0;
                            done_tx   = 1'b1;
                            ucnt      = $urandom_range(1, 3);
                            ust       = 2;
                        end
                    end
                    default: begin
                        ucnt--;
                        if (ucnt == 0) begin
                            done_tx = 1'b0;
                            ust     = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Scoreboard: bytes in FIFO are a queue; each start pops the oldest one.
    always @(negedge clk) begin
        if (!rst) begin
            model_q.delete();
            pend       = 1'b0;
            prev_start = 1'b0;
            prev_done  = 1'b0;
            done_seen  = 1'b0;
        end else begin
            if (pend) begin
                model_q.push_back(pend_dat);
                pend = 1'b0;
            end
            if (start) begin
                launches++;
                chk("start_one_cycle", prev_start, 0);
                chk("launch_has_data", model_q.size() != 0, 1);
                if (model_q.size() != 0) begin
                    chk("launch_order", tx_data_in, model_q.pop_front());
                end
                if (done_seen) begin
                    chk("launch_gap", (cyc - done_cyc) >= (GAP + 1), 1);
                end
                done_seen = 1'b0;
            end
            chk("count", count, model_q.size());
            chk("empty", empty, model_q.size() == 0);
            chk("full", full, model_q.size() == DEP);
            chk("wr_ready", wr_ready, model_q.size() < DEP);
            if (done_tx && !prev_done) begin
                done_cyc  = cyc + 1;
                done_seen = 1'b1;
            end
            prev_done  = done_tx;
            prev_start = start;
            if (wr_valid && wr_ready) begin
                pend     = 1'b1;
                pend_dat = wr_data;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic push(input logic [DW-1:0] d);
        logic acc;
        int   budget;
        acc    = 1'b0;
        budget = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!acc && budget < 3000) begin
            @(negedge clk);
            acc = wr_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        wr_valid = 1'b0;
        chk("push_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        int run;
        int budget;
        run    = 0;
        budget = 0;
        while (run < 12 && budget < 5000) begin
            @(posedge clk);
            #1;
            budget++;
            if (count == 0 && !uart_busy && !done_tx && !start) run++;
            else run = 0;
        end
        chk("drain_done", run >= 12, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        rst       = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        uart_hold = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_tx_data", tx_data_in, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single byte: exact launch latency
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        chk("single_count_after_write", count, 1);
        chk("single_start_not_yet", start, 0);
        @(posedge clk);
        #1;
        chk("single_start_high", start, 1);
        chk("single_tx_data", tx_data_in, 8'hA5);
        @(posedge clk);
        #1;
        chk("single_start_low", start, 0);
        chk("single_tx_data_held", tx_data_in, 8'hA5);
        wait_idle();
        chk("single_loopback", rx_byte, 8'hA5);

        // Burst fill with UART held busy, then overflow attempt
        uart_hold = 1'b1;
        l0 = launches;
        for (int i = 1; i <= 16; i++) push(8'(i));
        chk("burst_full", full, 1);
        chk("burst_wr_ready", wr_ready, 0);
        chk("burst_count", count, 16);
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("overflow_count", count, 16);
        end
        wr_valid  = 1'b0;
        uart_hold = 1'b0;
        wait_idle();
        chk("burst_launches", launches - l0, 16);

        // Wrap-around: random batch, drain, then 20..29
        l0 = launches;
        for (int i = 0; i < 10; i++) push(8'($urandom));
        wait_idle();
        for (int i = 0; i < 10; i++) push(8'(8'h20 + i));
        wait_idle();
        chk("wrap_launches", launches - l0, 20);

        // Write on the same edge as the IDLE pop
        uart_hold = 1'b1;
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        chk("simul_pre_count", count, 3);
        uart_hold = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 8'h77;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        chk("simul_count", count, 3);
        chk("simul_start", start, 1);
        wait_idle();

        // Random traffic
        l0 = launches;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(posedge clk);
            #1;
            push(8'($urandom));
        end
        wait_idle();
        chk("random_launches", launches - l0, 40);

        // Reset during WAIT_DONE with bytes queued
        uart_hold = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
        uart_hold = 1'b0;
        begin
            int b;
            b = 0;
            while (!start && b < 50) begin
                @(posedge clk);
                #1;
                b++;
            end
            chk("midrst_launch_seen", start, 1);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_start", start, 0);
        chk("midrst_wr_ready", wr_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        l0 = launches;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_start", launches - l0, 0);
        push(8'h5A);
        wait_idle();
        chk("midrst_new_launch", launches - l0, 1);
        chk("midrst_loopback", rx_byte, 8'h5A);
        chk("final_model_empty", model_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered front-end feeding the UART transmitter's start/tx_data_in handshake.
- Producers push bytes with a valid/ready handshake. The block stores them in a circular FIFO and launches one UART transmission per byte, in order.
- Waits for done_tx before each next launch, so producers never need to track UART timing.
- Sits directly upstream of UART's tx_data_in/start/done_tx/tx_active ports.

Parameters:
- DATA_WIDTH, 8, byte width; must match UART DATA_WIDTH.
- DEPTH, 16, FIFO entries; power of 2, >=2.
- GAP_CYCLES, 2, idle clocks between done_tx and the next launch; legal range 0..255.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst  in  1  reset; asynchronous, active-low.
- wr_data  in  DATA_WIDTH  byte to enqueue.
- wr_valid  in  1  producer offers wr_data.
- wr_ready  out  1  FIFO can accept; equals !full.
- tx_data_in  out  DATA_WIDTH  byte presented to UART; registered.
- start  out  1  one-cycle launch pulse to UART; registered.
- tx_active  in  1  UART transmitter busy.
- done_tx  in  1  UART transmission complete; pulse or level.
- count  out  $clog2(DEPTH)+1  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (rst low, async):
  - wr/rd pointers=0, count=0, empty=1, full=0, wr_ready=1.
  - start=0, tx_data_in=0, FSM=IDLE, gap counter=0.
  - Storage contents are don't-care.
- Write: accepted on rising clk when wr_valid && wr_ready. wr_data is stored at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Write when full: wr_ready=0, so no write occurs. Data and pointers are unchanged and no error is raised.
- Pop: occurs only on the LAUNCH transition. The head entry is copied into tx_data_in and rd_ptr increments with wrap.
- Simultaneous write and pop: count is unchanged. A write when full is still refused, even if a pop happens in the same cycle; wr_ready reflects registered full.
- FSM states:
  - IDLE: if !empty && !tx_active, go to LAUNCH. On that edge, register tx_data_in <= head, set start <= 1, and pop.
  - LAUNCH (1 cycle): start=1. Next state is WAIT_DONE with start <= 0.
  - WAIT_DONE: hold tx_data_in. On done_tx==1, go to GAP, loading the gap counter with GAP_CYCLES.
  - GAP: decrement each cycle; at 0, go to DRAIN. With GAP_CYCLES=0, go straight to DRAIN.
  - DRAIN: wait until done_tx==0 and tx_active==0, then go to IDLE. This makes a level-held done_tx safe.
- Latency: a byte written at edge N into an empty FIFO, with the FSM in IDLE and UART idle:
  - count=1 after edge N.
  - start high from edge N+1 to edge N+2.
  - tx_data_in valid from edge N+1.
- tx_data_in is stable from LAUNCH until the next LAUNCH.
- Ordering: bytes are transmitted strictly FIFO; no byte is dropped or duplicated.
- Wrap-around: pointers wrap modulo DEPTH; count is an independent up/down counter.
- Full/empty are derived from count, so no pointer-equality ambiguity arises.
- Reset mid-operation: all state clears immediately and the queued bytes are discarded. start falls asynchronously. The UART is responsible for abandoning its frame on the shared reset.

Optional Feature:
- Macro: UART_TX_FIFO_STATS_EN.
- When defined, adds ports:
  - tx_count out 16: bytes launched; increments on each LAUNCH entry and saturates at 16'hFFFF.
  - drop_count out 16: cycles with wr_valid && !wr_ready; saturating.
  - stats_clr in 1: synchronous clear of both counters; takes priority over increments.
  - Both counters reset to 0.
- When undefined, these ports and counters do not exist and the core behaviour is identical.

Test Plan:
- Single byte: reset, write 8'hA5 into an empty FIFO.
  - Required: start pulses exactly 1 cycle, 2 clocks after the write, with tx_data_in=8'hA5.
  - Loopback rx_data_out=8'hA5 after done_tx.
- Burst ordering: write 8'h01..8'h10 back-to-back (16 bytes, DEPTH=16).
  - Required: full=1 and wr_ready=0 after the 16th write.
  - Required: start pulses 16 times, data sequence 01..10, each launch ≥GAP_CYCLES+1 clocks after the preceding done_tx.
- Overflow: with the FIFO full, hold wr_valid with 8'hFF for 5 cycles.
  - Required: count stays 16 and 8'hFF is never transmitted.
  - With STATS_EN: drop_count=5.
- Wrap-around: write 10, drain 10, write 10 (values 8'h20..8'h29).
  - Required: pointers wrap and the transmit order is 20..29.
- Simultaneous: at count=3, assert wr_valid on the same edge as the IDLE→LAUNCH pop.
  - Required: count remains 3 and the order is preserved.
- Mid-operation reset: drive rst low during WAIT_DONE with 4 bytes queued.
  - Required: immediately count=0, empty=1, start=0.
  - Required: after release, no start until a new write.
